// File: rtl/sramc_pkg.sv
// Shared constants for the AHB-Lite SRAM controller.
// Bus codes, BIST states/patterns, geometry, byte-enable helper.
package sramc_pkg;

  localparam int SRAMC_AW    = 16;
  localparam int SRAMC_DEPTH = 8192;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [2:0] BIST_IDLE = 3'd0;
  localparam logic [2:0] BIST_W55  = 3'd1;
  localparam logic [2:0] BIST_R55  = 3'd2;
  localparam logic [2:0] BIST_WAA  = 3'd3;
  localparam logic [2:0] BIST_RAA  = 3'd4;
  localparam logic [2:0] BIST_DONE = 3'd5;

  localparam logic [7:0] PAT_55 = 8'h55;
  localparam logic [7:0] PAT_AA = 8'hAA;

  function automatic logic [3:0] byte_en(
    input logic [2:0] sz,
    input logic [1:0] a
  );
    logic [3:0] be;
    unique case (sz)
      HSIZE_BYTE: be = 4'b0001 << a;
      HSIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sram_8kx8.sv
// Synchronous single-port 8K x 8 array.
// Registered read, write-no-read; contents are not reset.
import sramc_pkg::*;

module sram_8kx8 #(
  parameter int DEPTH = SRAMC_DEPTH
) (
  input  logic        clk,
  input  logic        cs,
  input  logic        we,
  input  logic [12:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout
);

  logic [7:0] mem [DEPTH];

  // One access per cycle: write, or read into dout.
  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite zero-wait-state controller for 64 KB SRAM (8 x 8Kx8).
// Optional march BIST built when SRAMC_BIST_EN is defined.
import sramc_pkg::*;

module ahb_sram_ctrl #(
  parameter int AW    = SRAMC_AW,
  parameter int DEPTH = SRAMC_DEPTH
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic        hwrite,
  input  logic        hready,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  input  logic [31:0] haddr,
  input  logic        dft_en,
  input  logic        bist_en,
  output logic        hready_resp,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic        bist_done,
  output logic [7:0]  bist_fail
);

  localparam int IW = AW - 3;

  logic          go, rd_go, wr_go;
  logic          a_bank;
  logic [IW-1:0] a_idx;
  logic [3:0]    a_be;
  logic          unused_ok;

  assign hready_resp = 1'b1;
  assign hresp       = 2'b00;

  assign go     = hsel & hready & htrans[1]
                & ~dft_en & ~bist_en;
  assign rd_go  = go & ~hwrite;
  assign wr_go  = go & hwrite;
  assign a_bank = haddr[AW-1];
  assign a_idx  = haddr[AW-2:2];
  assign a_be   = byte_en(hsize, haddr[1:0]);

  assign unused_ok = ^{hburst, haddr[31:AW], htrans[0]};

  logic          wp_v_q, wp_bank_q;
  logic [IW-1:0] wp_idx_q;
  logic [3:0]    wp_be_q;

  logic          wb_v_q, wb_v_d;
  logic          wb_bank_q, wb_bank_d;
  logic [IW-1:0] wb_idx_q, wb_idx_d;
  logic [3:0]    wb_be_q, wb_be_d;
  logic [31:0]   wb_data_q, wb_data_d;

  logic          rd_v_q, rd_bank_q;
  logic [3:0]    fwd_be_q, fwd_be_d;
  logic [31:0]   fwd_data_q;
  logic [31:0]   hold_q;

  logic          c_v, c_bank, c_conf, c_wr, c_hit;
  logic [IW-1:0] c_idx;
  logic [3:0]    c_be;
  logic [31:0]   c_data;

  logic [7:0][7:0] arr_dout;
  logic [31:0]     rd_word;

  logic          bist_run, bist_wr, flush;
  logic [IW-1:0] bist_addr;
  logic [7:0]    bist_pat;

  // Write candidate: a held buffer entry wins over the
  // data phase in flight; it stalls only on a same-bank read.
  always_comb begin
    c_v    = wb_v_q | (wp_v_q & ~dft_en);
    c_bank = wb_v_q ? wb_bank_q : wp_bank_q;
    c_idx  = wb_v_q ? wb_idx_q  : wp_idx_q;
    c_be   = wb_v_q ? wb_be_q   : wp_be_q;
    c_data = wb_v_q ? wb_data_q : hwdata;
    c_conf = rd_go & (a_bank == c_bank);
    c_wr   = c_v & ~dft_en & ~bist_run & ~c_conf;
    c_hit  = c_v & c_conf & (a_idx == c_idx);
  end

  // Buffer a write whose port was taken by a read.
  always_comb begin
    wb_v_d    = wb_v_q;
    wb_bank_d = wb_bank_q;
    wb_idx_d  = wb_idx_q;
    wb_be_d   = wb_be_q;
    wb_data_d = wb_data_q;
    if (c_wr) begin
      wb_v_d = 1'b0;
    end else if (c_v && !wb_v_q) begin
      wb_v_d    = 1'b1;
      wb_bank_d = wp_bank_q;
      wb_idx_d  = wp_idx_q;
      wb_be_d   = wp_be_q;
      wb_data_d = hwdata;
    end
    if (flush) wb_v_d = 1'b0;
    fwd_be_d = (rd_go && c_hit) ? c_be : 4'b0000;
  end

  // Address-phase, buffer and forwarding registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wp_v_q     <= 1'b0;
      wp_bank_q  <= 1'b0;
      wp_idx_q   <= '0;
      wp_be_q    <= '0;
      wb_v_q     <= 1'b0;
      wb_bank_q  <= 1'b0;
      wb_idx_q   <= '0;
      wb_be_q    <= '0;
      wb_data_q  <= '0;
      rd_v_q     <= 1'b0;
      rd_bank_q  <= 1'b0;
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
      hold_q     <= '0;
    end else begin
      wp_v_q     <= wr_go;
      if (wr_go) begin
        wp_bank_q <= a_bank;
        wp_idx_q  <= a_idx;
        wp_be_q   <= a_be;
      end
      wb_v_q     <= wb_v_d;
      wb_bank_q  <= wb_bank_d;
      wb_idx_q   <= wb_idx_d;
      wb_be_q    <= wb_be_d;
      wb_data_q  <= wb_data_d;
      rd_v_q     <= rd_go;
      if (rd_go) begin
        rd_bank_q  <= a_bank;
        fwd_be_q   <= fwd_be_d;
        fwd_data_q <= c_data;
      end
      hold_q     <= hrdata;
    end
  end

  // Read data: array bytes, overlaid with forwarded bytes.
  always_comb begin
    rd_word = '0;
    for (int l = 0; l < 4; l++) begin
      rd_word[8*l +: 8] = fwd_be_q[l]
        ? fwd_data_q[8*l +: 8]
        : arr_dout[{rd_bank_q, 2'(l)}];
    end
    hrdata = rd_v_q ? rd_word : hold_q;
  end

  for (genvar i = 0; i < 8; i++) begin : g_arr
    localparam logic BK = (i >= 4);
    localparam int   LN = i % 4;
    logic          cs, we;
    logic [IW-1:0] ad;
    logic [7:0]    di;

    // Port owner: BIST, then bus read, then write.
    always_comb begin
      cs = 1'b0;
      we = 1'b0;
      ad = a_idx;
      di = c_data[8*LN +: 8];
      if (bist_run) begin
        cs = 1'b1;
        we = bist_wr;
        ad = bist_addr;
        di = bist_pat;
      end else if (rd_go && a_bank == BK) begin
        cs = 1'b1;
      end else if (c_wr && c_bank == BK
                   && c_be[LN]) begin
        cs = 1'b1;
        we = 1'b1;
        ad = c_idx;
      end
    end

    sram_8kx8 #(.DEPTH(DEPTH)) u_ram (
      .clk  (hclk),
      .cs   (cs),
      .we   (we),
      .addr (ad),
      .din  (di),
      .dout (arr_dout[i])
    );
  end

`ifdef SRAMC_BIST_EN
  logic [2:0]    bst_q, bst_d;
  logic [IW-1:0] bad_q, bad_d;
  logic          chk_q, chk_d;
  logic [7:0]    exp_q, exp_d;
  logic [7:0]    fail_q, fail_d;
  logic          last;

  assign last = (bad_q == IW'(DEPTH - 1));

  // March sequencer; compares lag reads by one cycle.
  always_comb begin
    bst_d  = bst_q;
    bad_d  = bad_q;
    chk_d  = 1'b0;
    exp_d  = exp_q;
    fail_d = fail_q;
    if (chk_q) begin
      for (int i = 0; i < 8; i++) begin
        if (arr_dout[i] != exp_q) fail_d[i] = 1'b1;
      end
    end
    if (!bist_en) begin
      bst_d = BIST_IDLE;
      bad_d = '0;
    end else begin
      unique case (bst_q)
        BIST_IDLE: begin
          fail_d = '0;
          bad_d  = '0;
          bst_d  = BIST_W55;
        end
        BIST_W55, BIST_WAA: begin
          bad_d = bad_q + 1'b1;
          if (last) begin
            bad_d = '0;
            bst_d = (bst_q == BIST_W55)
                  ? BIST_R55 : BIST_RAA;
          end
        end
        BIST_R55, BIST_RAA: begin
          chk_d = 1'b1;
          exp_d = (bst_q == BIST_R55)
                ? PAT_55 : PAT_AA;
          bad_d = bad_q + 1'b1;
          if (last) begin
            bad_d = '0;
            bst_d = (bst_q == BIST_R55)
                  ? BIST_WAA : BIST_DONE;
          end
        end
        BIST_DONE: bst_d = BIST_DONE;
        default:   bst_d = BIST_IDLE;
      endcase
    end
  end

  // BIST state, address and sticky flags.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      bst_q  <= BIST_IDLE;
      bad_q  <= '0;
      chk_q  <= 1'b0;
      exp_q  <= '0;
      fail_q <= '0;
    end else begin
      bst_q  <= bst_d;
      bad_q  <= bad_d;
      chk_q  <= chk_d;
      exp_q  <= exp_d;
      fail_q <= fail_d;
    end
  end

  assign bist_run  = (bst_q == BIST_W55) | (bst_q == BIST_R55)
                   | (bst_q == BIST_WAA) | (bst_q == BIST_RAA);
  assign bist_wr   = (bst_q == BIST_W55) | (bst_q == BIST_WAA);
  assign bist_pat  = (bst_q == BIST_W55) ? PAT_55 : PAT_AA;
  assign bist_addr = bad_q;
  assign flush     = bist_en;
  assign bist_done = (bst_q == BIST_DONE) & ~chk_q;
  assign bist_fail = fail_q;
`else
  assign bist_run  = 1'b0;
  assign bist_wr   = 1'b0;
  assign bist_pat  = 8'h00;
  assign bist_addr = '0;
  assign flush     = 1'b0;
  assign bist_done = 1'b0;
  assign bist_fail = 8'h00;
`endif

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed self-checking bench for ahb_sram_ctrl.
// BIST section is active when SRAMC_BIST_EN is defined.
module tb_ahb_sram_ctrl;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel, hwrite, hready;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;
  logic [31:0] hwdata, haddr;
  logic        dft_en, bist_en;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        bist_done;
  logic [7:0]  bist_fail;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd;

  always #5 hclk = ~hclk;

  ahb_sram_ctrl dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hsel        (hsel),
    .hwrite      (hwrite),
    .hready      (hready),
    .hsize       (hsize),
    .hburst      (hburst),
    .htrans      (htrans),
    .hwdata      (hwdata),
    .haddr       (haddr),
    .dft_en      (dft_en),
    .bist_en     (bist_en),
    .hready_resp (hready_resp),
    .hresp       (hresp),
    .hrdata      (hrdata),
    .bist_done   (bist_done),
    .bist_fail   (bist_fail)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hready = 1'b1;
  endtask

  // Write attempt with explicit qualifiers; ends after commit edge.
  task automatic xfer_wr(input logic s, input logic [1:0] t,
                         input logic rdy, input logic [31:0] a,
                         input logic [2:0] sz,
                         input logic [31:0] d);
    hsel = s; htrans = t; hready = rdy;
    hwrite = 1'b1; haddr = a; hsize = sz;
    @(negedge hclk);
    idle();
    hwdata = d;
    @(negedge hclk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz,
                    input logic [31:0] d);
    xfer_wr(1'b1, 2'b10, 1'b1, a, sz, d);
  endtask

  task automatic rdw(input logic [31:0] a, input logic [2:0] sz,
                     output logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; hready = 1'b1;
    hwrite = 1'b0; haddr = a; hsize = sz;
    @(negedge hclk);
    idle();
    d = hrdata;
  endtask

`ifdef SRAMC_BIST_EN
  task automatic run_bist(input string tag,
                          input logic [7:0] exp_fail);
    int n;
    n = 0;
    bist_en = 1'b1;
    while (!bist_done && n < 40000) begin
      @(negedge hclk);
      n++;
    end
    chk({tag, "_done"}, 32'(bist_done), 32'd1);
    chk({tag, "_len"}, 32'(n >= 4 * 8192), 32'd1);
    chk({tag, "_fail"}, 32'(bist_fail), 32'(exp_fail));
    bist_en = 1'b0;
    @(negedge hclk);
    chk({tag, "_clr"}, 32'(bist_done), 32'd0);
    chk({tag, "_keep"}, 32'(bist_fail), 32'(exp_fail));
  endtask
`endif

  initial begin
    hresetn = 1'b0;
    idle();
    hsize = 3'd2; hburst = 3'd0;
    hwdata = '0; haddr = '0;
    dft_en = 1'b0; bist_en = 1'b0;
    repeat (3) @(negedge hclk);
    chk("rst_hready", 32'(hready_resp), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_done", 32'(bist_done), 32'd0);
    chk("rst_fail", 32'(bist_fail), 32'd0);
    hresetn = 1'b1;
    @(negedge hclk);

    wr(32'h8000, 3'd2, 32'h11223344);
    wr(32'h0000, 3'd2, 32'h000123AF);
    rdw(32'h0000, 3'd2, rd);
    chk("word_rd", rd, 32'h000123AF);
    rdw(32'h8000, 3'd2, rd);
    chk("bank1_rd", rd, 32'h11223344);

    wr(32'h0002, 3'd0, 32'h00EE0000);
    rdw(32'h0000, 3'd2, rd);
    chk("byte_wr", rd, 32'h00EE23AF);
    wr(32'h0000, 3'd1, 32'h0000BEEF);
    rdw(32'h0000, 3'd2, rd);
    chk("half_wr", rd, 32'h00EEBEEF);

    repeat (3) @(negedge hclk);
    chk("hold", hrdata, 32'h00EEBEEF);

    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
    haddr = 32'h0100; hsize = 3'd2;
    @(negedge hclk);
    hwdata = 32'hCAFEF00D; hwrite = 1'b0;
    @(negedge hclk);
    idle();
    chk("fwd_word", hrdata, 32'hCAFEF00D);

    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
    haddr = 32'h0104; hsize = 3'd2;
    @(negedge hclk);
    hwdata = 32'h12345678; hwrite = 1'b0;
    haddr = 32'h0100;
    @(negedge hclk);
    idle();
    chk("conf_rd", hrdata, 32'hCAFEF00D);
    @(negedge hclk);
    rdw(32'h0104, 3'd2, rd);
    chk("conf_wr", rd, 32'h12345678);

    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
    haddr = 32'h0102; hsize = 3'd1;
    @(negedge hclk);
    hwdata = 32'h77660000; hwrite = 1'b0;
    haddr = 32'h0100; hsize = 3'd2;
    @(negedge hclk);
    idle();
    chk("fwd_half", hrdata, 32'h7766F00D);

    wr(32'h0103, 3'd1, 32'hA5A50000);
    rdw(32'h0100, 3'd2, rd);
    chk("misalign", rd, 32'hA5A5F00D);

    xfer_wr(1'b1, 2'b00, 1'b1, 32'h0, 3'd2, 32'hFFFFFFFF);
    rdw(32'h0000, 3'd2, rd);
    chk("idle_wr", rd, 32'h00EEBEEF);
    xfer_wr(1'b1, 2'b01, 1'b1, 32'h0, 3'd2, 32'hFFFFFFFF);
    rdw(32'h0000, 3'd2, rd);
    chk("busy_wr", rd, 32'h00EEBEEF);
    xfer_wr(1'b0, 2'b10, 1'b1, 32'h0, 3'd2, 32'hFFFFFFFF);
    rdw(32'h0000, 3'd2, rd);
    chk("nosel_wr", rd, 32'h00EEBEEF);
    xfer_wr(1'b1, 2'b10, 1'b0, 32'h0, 3'd2, 32'hFFFFFFFF);
    rdw(32'h0000, 3'd2, rd);
    chk("nordy_wr", rd, 32'h00EEBEEF);

    dft_en = 1'b1;
    wr(32'h0000, 3'd2, 32'hFFFFFFFF);
    dft_en = 1'b0;
    rdw(32'h0000, 3'd2, rd);
    chk("dft_wr", rd, 32'h00EEBEEF);
    dft_en = 1'b1;
    rdw(32'h0100, 3'd2, rd);
    chk("dft_rd", rd, 32'h00EEBEEF);
    dft_en = 1'b0;

    hburst = 3'd1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
    haddr = 32'h0200; hsize = 3'd2;
    @(negedge hclk);
    hwdata = 32'hA1A2A3A4;
    htrans = 2'b11; haddr = 32'h0204;
    @(negedge hclk);
    hwdata = 32'hB1B2B3B4;
    idle();
    @(negedge hclk);
    hburst = 3'd0;
    rdw(32'h0200, 3'd2, rd);
    chk("burst0", rd, 32'hA1A2A3A4);
    rdw(32'h0204, 3'd2, rd);
    chk("burst1", rd, 32'hB1B2B3B4);

    wr(32'h0300, 3'd3, 32'h0BADF00D);
    rdw(32'h0301, 3'd0, rd);
    chk("size3_wr", rd, 32'h0BADF00D);

`ifdef SRAMC_BIST_EN
    run_bist("bist_ok", 8'h00);
    force dut.g_arr[3].u_ram.dout[0] = 1'b1;
    run_bist("bist_bad", 8'h08);
    release dut.g_arr[3].u_ram.dout[0];
`else
    bist_en = 1'b1;
    wr(32'h0000, 3'd2, 32'hFFFFFFFF);
    repeat (4) @(negedge hclk);
    chk("nobist_done", 32'(bist_done), 32'd0);
    chk("nobist_fail", 32'(bist_fail), 32'd0);
    bist_en = 1'b0;
    rdw(32'h0000, 3'd2, rd);
    chk("bist_blk", rd, 32'h00EEBEEF);
`endif

    chk("end_resp", {29'd0, hresp, hready_resp}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
